// File: rtl/ifu_fetch_if.sv
// -----------------------------------------------------------------------------
// ifu_fetch_if
//   Bundle of every non-clock signal of the instruction fetch unit: the PC
//   register read port, the instruction-memory request/response channels and
//   the decode-side instruction handshake.
//
//   master : the fetch unit (drives mem_req_*, inst*, fetch_fault)
//   slave  : the surroundings (PC register, memory, decode)
//
//   pc, pc_wen         PC register value and its write enable
//   mem_req_valid/addr fetch request, mem_req_ready accepts it
//   mem_rsp_valid/data response word, mem_rsp_err flags a bus error
//   inst_valid/inst    instruction to decode, inst_pc its address,
//   fetch_fault        qualifies inst_valid, inst_ready accepts it
// -----------------------------------------------------------------------------
interface ifu_fetch_if;
   logic [31:0] pc;
   logic        pc_wen;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        mem_rsp_err;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        fetch_fault;
   logic        inst_ready;

   modport master (
      input  pc, pc_wen, mem_req_ready, mem_rsp_valid, mem_rsp_data,
             mem_rsp_err, inst_ready,
      output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
             fetch_fault
   );

   modport slave (
      output pc, pc_wen, mem_req_ready, mem_rsp_valid, mem_rsp_data,
             mem_rsp_err, inst_ready,
      input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
             fetch_fault
   );
endinterface

// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch
//   Instruction fetch unit of the single-issue NPC core. Reads the current PC,
//   issues one memory read for it, hands the returned word to decode and then
//   waits for the PC register to be rewritten before fetching again, so at
//   most one fetch is ever in flight.
//
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset
//     bus  ifu_fetch_if.master (PC read port, memory request/response,
//          decode handshake)
//
//   Parameter:
//     RESET_PC  value of inst_pc after reset (matches the PC register reset)
//
//   Configuration macro IFU_FLUSH_EN:
//     defined   - pc_wen during an outstanding fetch or while an instruction is
//                 held redirects the unit; a stale response is dropped.
//     undefined - pc_wen is only legal in HOLD (with inst_ready) and DONE;
//                 elsewhere it is ignored and a simulation assertion fires.
// -----------------------------------------------------------------------------
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   ifu_fetch_if.master bus
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        fault_q, fault_d;
   logic        req_valid;
   logic        hold_valid;
   logic        misaligned;

`ifdef IFU_FLUSH_EN
   // Set when the outstanding request belongs to a PC that has since been
   // replaced; the matching response must be thrown away.
   logic        drop_q, drop_d;
`endif

   assign misaligned = |bus.pc[1:0];

   always_comb begin
      state_d    = state_q;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      fault_d    = fault_q;
      req_valid  = 1'b0;
      hold_valid = 1'b0;
`ifdef IFU_FLUSH_EN
      drop_d     = drop_q;
`endif

      case (state_q)
         S_REQ: begin
            if (misaligned) begin
               // Never send a misaligned address to memory; report it instead.
               inst_pc_d = bus.pc;
               inst_d    = 32'h0;
               fault_d   = 1'b1;
               state_d   = S_HOLD;
            end else begin
               req_valid = 1'b1;
               if (bus.mem_req_ready) begin
                  inst_pc_d = bus.pc;
                  state_d   = S_WAIT;
`ifdef IFU_FLUSH_EN
                  // The request just accepted carries the old PC.
                  drop_d    = bus.pc_wen;
`endif
               end
            end
         end

         S_WAIT: begin
`ifdef IFU_FLUSH_EN
            if (bus.pc_wen) begin
               drop_d = 1'b1;
            end
            if (bus.mem_rsp_valid) begin
               drop_d = 1'b0;
               if (drop_q || bus.pc_wen) begin
                  state_d = S_REQ;
               end else begin
                  inst_d  = bus.mem_rsp_err ? 32'h0 : bus.mem_rsp_data;
                  fault_d = bus.mem_rsp_err;
                  state_d = S_HOLD;
               end
            end
`else
            if (bus.mem_rsp_valid) begin
               inst_d  = bus.mem_rsp_err ? 32'h0 : bus.mem_rsp_data;
               fault_d = bus.mem_rsp_err;
               state_d = S_HOLD;
            end
`endif
         end

         S_HOLD: begin
            hold_valid = 1'b1;
            if (bus.inst_ready) begin
               // A simultaneous PC write skips DONE so the refetch starts at once.
               state_d = bus.pc_wen ? S_REQ : S_DONE;
`ifdef IFU_FLUSH_EN
            end else if (bus.pc_wen) begin
               state_d = S_REQ;
`endif
            end
         end

         S_DONE: begin
            if (bus.pc_wen) begin
               state_d = S_REQ;
            end
         end

         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_REQ;
         inst_q    <= 32'h0;
         inst_pc_q <= RESET_PC;
         fault_q   <= 1'b0;
`ifdef IFU_FLUSH_EN
         drop_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         fault_q   <= fault_d;
`ifdef IFU_FLUSH_EN
         drop_q    <= drop_d;
`endif
      end
   end

   // Handshake outputs are masked during reset so nothing is offered while
   // the state register still holds a pre-reset value.
   assign bus.mem_req_valid = req_valid & ~rst;
   assign bus.mem_req_addr  = bus.pc;
   assign bus.inst_valid    = hold_valid & ~rst;
   assign bus.inst          = inst_q;
   assign bus.inst_pc       = inst_pc_q;
   assign bus.fetch_fault   = fault_q;

`ifndef IFU_FLUSH_EN
`ifndef SYNTHESIS
   // Rewriting the PC while a fetch is being issued or is outstanding is not
   // supported without redirect support.
   a_no_pc_wen_in_flight : assert property (
      @(posedge clk) disable iff (rst)
      !(bus.pc_wen && (state_q == S_REQ || state_q == S_WAIT))
   );
`endif
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_nxt;
   int          n_cmp  = 0;
   int          n_fail = 0;

   // results of the most recent run_fetch
   logic [31:0] r_inst, r_pc, r_hs_addr;
   logic        r_fault;
   int          r_nreq, r_nreqv, r_hs_cyc, r_ival_cyc, r_unstable;
   bit          r_timeout;

   ifu_fetch_if bus ();

   ifu_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // PC register: pc_wen makes pc_nxt visible from the next cycle on
   always @(posedge clk) begin
      if (rst) bus.pc <= RESET_PC;
      else if (bus.pc_wen) bus.pc <= pc_nxt;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   // One fetch seen from the memory/decode side. Starts at a point where the
   // unit sits in REQ; ends one cycle after decode accepted the instruction.
   task automatic run_fetch(input int req_stall, input int rsp_dly,
                            input logic [31:0] data, input logic err,
                            input int rdy_stall, input bit junk,
                            input bit wen_acc, input logic [31:0] nxt);
      int cyc; bit pending; int cnt; bit got; bit done;
      r_nreq = 0; r_nreqv = 0; r_hs_cyc = -1; r_ival_cyc = -1;
      r_unstable = 0; r_timeout = 0; r_hs_addr = 32'h0;
      cyc = 0; pending = 0; cnt = 0; got = 0; done = 0;
      while (!done) begin
         if (cyc >= 200) begin
            r_timeout = 1;
            break;
         end
         bus.mem_req_ready = 1'b0;
         bus.mem_rsp_valid = 1'b0;
         bus.mem_rsp_data  = 32'h0;
         bus.mem_rsp_err   = 1'b0;
         bus.inst_ready    = 1'b0;
         bus.pc_wen        = 1'b0;
         if (pending) begin
            if (cnt == 0) begin
               bus.mem_rsp_valid = 1'b1;
               bus.mem_rsp_data  = data;
               bus.mem_rsp_err   = err;
               pending = 0;
            end else begin
               cnt--;
            end
         end else if (junk && ($urandom_range(0, 1) == 1)) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = 32'h0BAD_0BAD;
            bus.mem_rsp_err   = 1'($urandom_range(0, 1));
         end
         if (bus.mem_req_valid) begin
            r_nreqv++;
            if (req_stall > 0) begin
               req_stall--;
            end else begin
               bus.mem_req_ready = 1'b1;
               r_nreq++;
               r_hs_cyc  = cyc;
               r_hs_addr = bus.mem_req_addr;
               pending   = 1;
               cnt       = rsp_dly;
            end
         end
         if (bus.inst_valid) begin
            if (!got) begin
               got = 1;
               r_ival_cyc = cyc;
               r_inst  = bus.inst;
               r_pc    = bus.inst_pc;
               r_fault = bus.fetch_fault;
            end else if (bus.inst !== r_inst || bus.inst_pc !== r_pc ||
                         bus.fetch_fault !== r_fault) begin
               r_unstable++;
            end
            if (rdy_stall > 0) begin
               rdy_stall--;
            end else begin
               bus.inst_ready = 1'b1;
               done = 1;
               if (wen_acc) begin
                  pc_nxt     = nxt;
                  bus.pc_wen = 1'b1;
               end
            end
         end
         @(negedge clk); #1;
         cyc++;
      end
      bus.inst_ready    = 1'b0;
      bus.pc_wen        = 1'b0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
   endtask

   // Rewrite the PC register for one cycle (unit must be in DONE).
   task automatic new_pc(input logic [31:0] a);
      pc_nxt     = a;
      bus.pc_wen = 1'b1;
      @(negedge clk); #1;
      bus.pc_wen = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.pc_wen = 1'b0; bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data = 32'h0; bus.mem_rsp_err = 1'b0; bus.inst_ready = 1'b0;
      pc_nxt = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", bus.mem_req_valid); end
      n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b want 0", bus.inst_valid); end
      n_cmp++; if (bus.inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 00000000", bus.inst); end
      n_cmp++; if (bus.inst_pc !== RESET_PC) begin n_fail++; $display("FAIL rst_inst_pc: got %h want %h", bus.inst_pc, RESET_PC); end
      n_cmp++; if (bus.fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", bus.fetch_fault); end
      bus.mem_req_ready = 1'b0;
      rst = 1'b0;
      #1;
      n_cmp++; if (bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %b want 1", bus.mem_req_valid); end
      n_cmp++; if (bus.mem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL first_req_addr: got %h want %h", bus.mem_req_addr, RESET_PC); end
   endtask

   task automatic test_basic();
      run_fetch(0, 0, 32'h0000_0413, 1'b0, 0, 0, 0, 32'h0);
      n_cmp++; if (r_timeout) begin n_fail++; $display("FAIL basic_timeout: got timeout want inst_valid"); end
      n_cmp++; if (r_hs_cyc !== 0) begin n_fail++; $display("FAIL basic_req_cycle: got %0d want 0", r_hs_cyc); end
      n_cmp++; if (r_ival_cyc !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", r_ival_cyc); end
      n_cmp++; if (r_inst !== 32'h0000_0413) begin n_fail++; $display("FAIL basic_inst: got %h want 00000413", r_inst); end
      n_cmp++; if (r_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_pc: got %h want 80000000", r_pc); end
      n_cmp++; if (r_fault !== 1'b0) begin n_fail++; $display("FAIL basic_fault: got %b want 0", r_fault); end
   endtask

   task automatic test_backpressure();
      logic [31:0] d;
      d = $urandom;
      new_pc(32'h8000_0010);
      run_fetch(3, 4, d, 1'b0, 2, 0, 0, 32'h0);
      n_cmp++; if (r_timeout) begin n_fail++; $display("FAIL bp_timeout: got timeout want inst_valid"); end
      n_cmp++; if (r_nreq !== 1) begin n_fail++; $display("FAIL bp_nreq: got %0d want 1", r_nreq); end
      n_cmp++; if (r_nreqv !== 4) begin n_fail++; $display("FAIL bp_req_valid_cycles: got %0d want 4", r_nreqv); end
      n_cmp++; if (r_hs_cyc !== 3) begin n_fail++; $display("FAIL bp_hs_cycle: got %0d want 3", r_hs_cyc); end
      n_cmp++; if (r_ival_cyc !== 9) begin n_fail++; $display("FAIL bp_ival_cycle: got %0d want 9", r_ival_cyc); end
      n_cmp++; if (r_unstable !== 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d changes want 0", r_unstable); end
      n_cmp++; if (r_inst !== d) begin n_fail++; $display("FAIL bp_inst: got %h want %h", r_inst, d); end
      n_cmp++; if (r_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL bp_pc: got %h want 80000010", r_pc); end
      n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done_ival: got %b want 0", bus.inst_valid); end
      n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done_req: got %b want 0", bus.mem_req_valid); end
      n_cmp++; if (bus.inst !== d) begin n_fail++; $display("FAIL bp_done_inst_held: got %h want %h", bus.inst, d); end
   endtask

   task automatic test_refetch();
      logic [31:0] d;
      d = $urandom;
      new_pc(32'h8000_0000);
      run_fetch(0, 0, 32'h1234_5678, 1'b0, 1, 0, 1, 32'h8000_0004);
      n_cmp++; if (bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL refetch_req_valid: got %b want 1", bus.mem_req_valid); end
      n_cmp++; if (bus.mem_req_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL refetch_addr: got %h want 80000004", bus.mem_req_addr); end
      run_fetch(0, 1, d, 1'b0, 0, 0, 0, 32'h0);
      n_cmp++; if (r_inst !== d) begin n_fail++; $display("FAIL refetch_inst: got %h want %h", r_inst, d); end
      n_cmp++; if (r_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL refetch_pc: got %h want 80000004", r_pc); end
   endtask

   task automatic test_misaligned();
      new_pc(32'h8000_0002);
      run_fetch(0, 0, 32'h1234_5678, 1'b0, 1, 0, 0, 32'h0);
      n_cmp++; if (r_timeout) begin n_fail++; $display("FAIL mis_timeout: got timeout want inst_valid"); end
      n_cmp++; if (r_nreqv !== 0) begin n_fail++; $display("FAIL mis_no_request: got %0d req cycles want 0", r_nreqv); end
      n_cmp++; if (r_ival_cyc !== 1) begin n_fail++; $display("FAIL mis_latency: got %0d want 1", r_ival_cyc); end
      n_cmp++; if (r_inst !== 32'h0) begin n_fail++; $display("FAIL mis_inst: got %h want 00000000", r_inst); end
      n_cmp++; if (r_fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault: got %b want 1", r_fault); end
      n_cmp++; if (r_pc !== 32'h8000_0002) begin n_fail++; $display("FAIL mis_pc: got %h want 80000002", r_pc); end
   endtask

   task automatic test_bus_error();
      new_pc(32'h8000_0020);
      run_fetch(0, 1, 32'hDEAD_BEEF, 1'b1, 0, 0, 0, 32'h0);
      n_cmp++; if (r_inst !== 32'h0) begin n_fail++; $display("FAIL err_inst: got %h want 00000000", r_inst); end
      n_cmp++; if (r_fault !== 1'b1) begin n_fail++; $display("FAIL err_fault: got %b want 1", r_fault); end
      n_cmp++; if (r_pc !== 32'h8000_0020) begin n_fail++; $display("FAIL err_pc: got %h want 80000020", r_pc); end
   endtask

   task automatic test_reset_abort();
      logic [31:0] d;
      new_pc(32'h8000_0100);
      bus.mem_req_ready = 1'b1;
      @(negedge clk); #1;
      bus.mem_req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk); #1;
      n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rst_req: got %b want 0", bus.mem_req_valid); end
      rst = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'h2222_2222;
      @(negedge clk); #1;
      bus.mem_rsp_valid = 1'b0;
      n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL abort_late_rsp_ival: got %b want 0", bus.inst_valid); end
      n_cmp++; if (bus.inst !== 32'h0) begin n_fail++; $display("FAIL abort_late_rsp_inst: got %h want 00000000", bus.inst); end
      n_cmp++; if (bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL abort_req_again: got %b want 1", bus.mem_req_valid); end
      d = $urandom;
      run_fetch(0, 0, d, 1'b0, 0, 0, 0, 32'h0);
      n_cmp++; if (r_inst !== d || r_pc !== RESET_PC) begin n_fail++; $display("FAIL abort_refetch: got %h@%h want %h@%h", r_inst, r_pc, d, RESET_PC); end
   endtask

`ifdef IFU_FLUSH_EN
   task automatic test_flush();
      // pc_wen while waiting for the response
      new_pc(32'h8000_0040);
      bus.mem_req_ready = 1'b1;
      @(negedge clk); #1;
      bus.mem_req_ready = 1'b0;
      pc_nxt = 32'h8000_0080; bus.pc_wen = 1'b1;
      @(negedge clk); #1;
      bus.pc_wen = 1'b0;
      n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wait_req: got %b want 0", bus.mem_req_valid); end
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h1111_1111;
      @(negedge clk); #1;
      bus.mem_rsp_valid = 1'b0;
      n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale_ival: got %b want 0", bus.inst_valid); end
      n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h8000_0080) begin n_fail++; $display("FAIL flush_new_req: got %b/%h want 1/80000080", bus.mem_req_valid, bus.mem_req_addr); end
      run_fetch(0, 0, 32'h3333_3333, 1'b0, 0, 0, 0, 32'h0);
      n_cmp++; if (r_inst !== 32'h3333_3333 || r_pc !== 32'h8000_0080) begin n_fail++; $display("FAIL flush_fetch: got %h@%h want 33333333@80000080", r_inst, r_pc); end
      // pc_wen in the same cycle as the request handshake
      new_pc(32'h8000_00C0);
      bus.mem_req_ready = 1'b1; pc_nxt = 32'h8000_0100; bus.pc_wen = 1'b1;
      @(negedge clk); #1;
      bus.mem_req_ready = 1'b0; bus.pc_wen = 1'b0;
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h4444_4444;
      @(negedge clk); #1;
      bus.mem_rsp_valid = 1'b0;
      n_cmp++; if (bus.inst_valid !== 1'b0 || bus.mem_req_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL flush_hs_drop: got %b/%h want 0/80000100", bus.inst_valid, bus.mem_req_addr); end
      run_fetch(0, 0, 32'h5555_5555, 1'b0, 0, 0, 0, 32'h0);
      n_cmp++; if (r_inst !== 32'h5555_5555 || r_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL flush_hs_fetch: got %h@%h want 55555555@80000100", r_inst, r_pc); end
      // pc_wen while an instruction is held and not accepted
      new_pc(32'h8000_0140);
      bus.mem_req_ready = 1'b1;
      @(negedge clk); #1;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'h6666_6666;
      @(negedge clk); #1;
      bus.mem_rsp_valid = 1'b0;
      n_cmp++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL flush_hold_ival: got %b want 1", bus.inst_valid); end
      pc_nxt = 32'h8000_0180; bus.pc_wen = 1'b1;
      @(negedge clk); #1;
      bus.pc_wen = 1'b0;
      n_cmp++; if (bus.inst_valid !== 1'b0 || bus.mem_req_addr !== 32'h8000_0180) begin n_fail++; $display("FAIL flush_hold_drop: got %b/%h want 0/80000180", bus.inst_valid, bus.mem_req_addr); end
      run_fetch(0, 0, 32'h7777_7777, 1'b0, 0, 0, 0, 32'h0);
      n_cmp++; if (r_inst !== 32'h7777_7777 || r_pc !== 32'h8000_0180) begin n_fail++; $display("FAIL flush_hold_fetch: got %h@%h want 77777777@80000180", r_inst, r_pc); end
   endtask
`endif

   task automatic test_random();
      logic [31:0] cur, nxt, d, exp_inst;
      logic        err, mis, exp_fault;
      bit          chain;
      cur = {$urandom} & 32'hFFFF_FFFC;
      new_pc(cur);
      for (int i = 0; i < 24; i++) begin
         nxt = {$urandom} & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) nxt[1:0] = 2'($urandom_range(1, 3));
         chain = (i < 23) && ($urandom_range(0, 1) == 1);
         d   = $urandom;
         err = ($urandom_range(0, 5) == 0);
         mis = (cur[1:0] != 2'b00);
         // expected result from the fetch rules alone
         exp_fault = mis | err;
         exp_inst  = exp_fault ? 32'h0 : d;
         run_fetch($urandom_range(0, 3), $urandom_range(0, 3), d, err,
                   $urandom_range(0, 3), 1, chain, nxt);
         n_cmp++; if (r_timeout) begin n_fail++; $display("FAIL rnd%0d_timeout: got timeout want inst_valid", i); end
         n_cmp++; if (r_inst !== exp_inst) begin n_fail++; $display("FAIL rnd%0d_inst: got %h want %h", i, r_inst, exp_inst); end
         n_cmp++; if (r_pc !== cur) begin n_fail++; $display("FAIL rnd%0d_pc: got %h want %h", i, r_pc, cur); end
         n_cmp++; if (r_fault !== exp_fault) begin n_fail++; $display("FAIL rnd%0d_fault: got %b want %b", i, r_fault, exp_fault); end
         n_cmp++; if (r_nreq !== (mis ? 0 : 1)) begin n_fail++; $display("FAIL rnd%0d_nreq: got %0d want %0d", i, r_nreq, mis ? 0 : 1); end
         n_cmp++; if (r_unstable !== 0) begin n_fail++; $display("FAIL rnd%0d_hold_stable: got %0d changes want 0", i, r_unstable); end
         if (!mis) begin
            n_cmp++; if (r_hs_addr !== cur) begin n_fail++; $display("FAIL rnd%0d_addr: got %h want %h", i, r_hs_addr, cur); end
         end
         if (!chain && i < 23) new_pc(nxt);
         cur = nxt;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_refetch();
      test_misaligned();
      test_bus_error();
      test_reset_abort();
`ifdef IFU_FLUSH_EN
      test_flush();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the single-issue NPC core. It is the consumer side of the PC register's `pc`/`pc_wen` interface. It reads the current PC, issues one instruction-memory read per PC value over a valid/ready request channel, and presents the returned instruction to the decode stage with a valid/ready handshake. It then waits for the PC register to be rewritten (`pc_wen`) before fetching again, so at most one fetch is ever in flight.

## Interface
Parameters:
- RESET_PC, 32'h80000000, value reported on `inst_pc` for the first fetch; must match the PC register reset value.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  current PC from the PC register.
- pc_wen  in  1  PC register write enable; when high, `pc` holds the new value from the next cycle on.
- mem_req_valid  out  1  fetch request valid.
- mem_req_addr  out  32  fetch address; equals `pc` while `mem_req_valid` is high.
- mem_req_ready  in  1  memory accepts request.
- mem_rsp_valid  in  1  read data valid; the response path has no ready signal and is always accepted.
- mem_rsp_data  in  32  instruction word.
- mem_rsp_err  in  1  bus error on this response.
- inst_valid  out  1  instruction available to decode.
- inst  out  32  instruction word; 32'h0 when `fetch_fault` is set.
- inst_pc  out  32  PC of `inst`.
- fetch_fault  out  1  qualifies `inst_valid`: misaligned PC or bus error.
- inst_ready  in  1  decode accepts instruction.

## Operation
The block is a four-state FSM: REQ, WAIT, HOLD, DONE. Reset state is REQ.

- **REQ**
  - `mem_req_valid`=1.
  - If `pc[1:0]`≠0: no request is issued (`mem_req_valid`=0). Latch `inst_pc`←`pc`, `inst`←0, `fetch_fault`←1, then go to HOLD.
  - On `mem_req_valid && mem_req_ready`: latch `inst_pc`←`pc`, then go to WAIT.
- **WAIT**
  - On `mem_rsp_valid`: latch `inst`←`mem_rsp_data` (0 if `mem_rsp_err`) and `fetch_fault`←`mem_rsp_err`, then go to HOLD.
  - `mem_rsp_valid` in any state other than WAIT is ignored.
- **HOLD**
  - `inst_valid`=1. `inst`, `inst_pc` and `fetch_fault` stay stable until `inst_ready`.
  - On `inst_ready`: go to DONE. If `pc_wen` is high in the same cycle, go directly to REQ.
- **DONE**
  - On `pc_wen`: go to REQ.
  - Otherwise stay in DONE.

Outputs:
- `inst`, `inst_pc` and `fetch_fault` are registers that hold their last value outside HOLD.
- `mem_req_addr` is driven combinationally from `pc`.

## Timing
- Reset values:
  - state=REQ
  - `inst_valid`=0, `mem_req_valid`=0 while `rst`=1
  - `inst`=0, `inst_pc`=RESET_PC, `fetch_fault`=0
- First request: `mem_req_valid`=1 in the first cycle after `rst` deasserts.
- Minimum latency, with a zero-wait memory:
  - request handshake in cycle N
  - response in cycle N+1
  - `inst_valid` in cycle N+2
- Misaligned PC: `inst_valid` one cycle after REQ is entered.
- Refetch: `pc_wen` in cycle M causes `mem_req_valid` in cycle M+1 with the new `pc`.
- `rst` asserted mid-operation, in any state, aborts the fetch. Any late response is dropped because the FSM is no longer in WAIT when it arrives.
- Without IFU_FLUSH_EN, `pc_wen` in REQ or WAIT is a protocol violation. It is ignored, and a simulation assertion fires.

## Configuration
Macro: IFU_FLUSH_EN.

Defined (redirect support):
- `pc_wen` in WAIT sets an internal drop flag. The pending response is discarded when it arrives and the FSM goes to REQ.
- `pc_wen` in the same cycle as a REQ handshake also sets the drop flag. The request used the old PC, so its response is discarded.
- `pc_wen` in HOLD without `inst_ready` discards the held instruction: `inst_valid` drops and the FSM goes to REQ.
- The drop flag clears on reset and when the FSM leaves WAIT.

Undefined:
- The drop flag and its logic are absent.
- Behaviour follows the Timing section.

## Test plan
- Reset, then `pc`=0x80000000 with always-ready memory returning 0x00000413:
  - `mem_req_valid` in the first post-reset cycle, `inst_valid` two cycles later
  - `inst`=0x00000413, `inst_pc`=0x80000000, `fetch_fault`=0
- Backpressure on both sides:
  - `mem_req_ready` held low for 3 cycles, response delayed 4 cycles, `inst_ready` low for 2 cycles
  - exactly one request is issued and `inst` stays stable through HOLD
- Refetch: `inst_ready` and `pc_wen` in the same cycle with new `pc`=0x80000004 → the next cycle shows `mem_req_valid`=1 and `mem_req_addr`=0x80000004.
- Misaligned `pc`=0x80000002 → no memory request, `inst_valid`=1 with `fetch_fault`=1, `inst`=0.
- Bus error: `mem_rsp_err`=1 with data 0xDEADBEEF → `inst`=0, `fetch_fault`=1.
- IFU_FLUSH_EN defined, `pc_wen` in WAIT:
  - the stale response 0x11111111 never appears on `inst`
  - the next fetch uses the new PC
